// File: rtl/turfio_cout_pkg.sv
// Shared types and constants for the SURF-side COUT transmit framer.
package turfio_cout_pkg;

  typedef enum logic [1:0] {
    COUT_OFF   = 2'd0,
    COUT_TRAIN = 2'd1,
    COUT_RUN   = 2'd2
  } cout_mode_t;

  localparam int          COUT_NIBBLES       = 8;
  localparam logic [31:0] COUT_OFF_WORD      = 32'hFFFF_FFFF;
  localparam logic [31:0] COUT_TRAIN_DEFAULT = 32'hA55A_6996;
  localparam logic [31:0] COUT_IDLE_DEFAULT  = 32'h0000_0000;

  // The unused encoding 2'b11 falls back to OFF so the line idles high.
  function automatic cout_mode_t cout_decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return COUT_TRAIN;
      2'd2:    return COUT_RUN;
      default: return COUT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/turfio_cout_phase.sv
// Nibble-phase counter for the COUT framer; boundary_o marks every word load point,
// including a realign requested through sync_i while sync_en_i is high.
module turfio_cout_phase
  import turfio_cout_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_i,
  input  logic       sync_en_i,
  output logic [2:0] phase_o,
  output logic       boundary_o
);

  localparam logic [2:0] LAST_PHASE = 3'(COUT_NIBBLES - 1);

  logic [2:0] phase_q, phase_d;

  always_comb begin
    boundary_o = (phase_q == LAST_PHASE) || (sync_i && sync_en_i);
    phase_d    = boundary_o ? 3'd0 : phase_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= 3'd0;
    else     phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/turfio_cout_surf_tx.sv
// SURF-side COUT transmit framer: 32-bit words out as nibbles, MSB nibble first, OFF/TRAIN/RUN.
// Optional macro TURFIO_COUT_TX_COUNT_EN enables the words_sent_o counter.
module turfio_cout_surf_tx
  import turfio_cout_pkg::*;
#(
  parameter logic        INV           = 1'b0,
  parameter logic [31:0] TRAIN_PATTERN = COUT_TRAIN_DEFAULT,
  parameter logic [31:0] IDLE_WORD     = COUT_IDLE_DEFAULT,
  parameter string       DEBUG         = "TRUE"
) (
  input  logic        rxclk_i,
  input  logic        rst_i,
  input  logic [1:0]  mode_i,
  input  logic        sync_i,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [3:0]  data_o,
  output logic [2:0]  phase_o,
  output logic [1:0]  mode_o,
  output logic        sync_err_o,
  output logic [15:0] words_sent_o
);

  cout_mode_t  mode_q, mode_d;
  logic [31:0] sr_q, sr_d;
  logic [3:0]  data_q, data_d;
  logic        sync_err_q, sync_err_d;
  logic        boundary;

  // A realign in RUN would corrupt a user word, so sync only acts outside RUN.
  turfio_cout_phase u_phase (
    .clk        (rxclk_i),
    .rst        (rst_i),
    .sync_i     (sync_i),
    .sync_en_i  (mode_q != COUT_RUN),
    .phase_o    (phase_o),
    .boundary_o (boundary)
  );

  always_comb begin
    mode_d     = boundary ? cout_decode_mode(mode_i) : mode_q;
    s_tready   = boundary && (mode_d == COUT_RUN) && !rst_i;
    sr_d       = sr_q << 4;
    if (boundary) begin
      case (mode_d)
        COUT_TRAIN: sr_d = TRAIN_PATTERN;
        COUT_RUN:   sr_d = s_tvalid ? s_tdata : IDLE_WORD;
        default:    sr_d = COUT_OFF_WORD;
      endcase
    end
    data_d     = sr_d[31:28] ^ {4{INV}};
    sync_err_d = sync_i && (mode_q == COUT_RUN);
  end

  always_ff @(posedge rxclk_i) begin
    if (rst_i) begin
      mode_q     <= COUT_OFF;
      sr_q       <= COUT_OFF_WORD;
      data_q     <= 4'hF ^ {4{INV}};
      sync_err_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign data_o     = data_q;
  assign mode_o     = mode_q;
  assign sync_err_o = sync_err_q;

`ifdef TURFIO_COUT_TX_COUNT_EN
  logic [15:0] words_q, words_d;

  always_comb words_d = words_q + ((s_tready && s_tvalid) ? 16'd1 : 16'd0);

  always_ff @(posedge rxclk_i) begin
    if (rst_i) words_q <= 16'h0000;
    else       words_q <= words_d;
  end

  assign words_sent_o = words_q;
`else
  assign words_sent_o = 16'h0000;
`endif

  // The vendor ILA on data_o is attached to this scope in the FPGA build.
  if (DEBUG == "TRUE") begin : g_ila
  end

endmodule
